// File: rtl/mixffn_pkg.sv
// Shared types and default sizing for the MixFFN sequencer.
package mixffn_pkg;

  // Datapath stage order; the encoding is also driven out on the stage port.
  typedef enum logic [1:0] {
    STG_FC1  = 2'd0,
    STG_DW   = 2'd1,
    STG_GELU = 2'd2,
    STG_FC2  = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_FC1_LEN  = 16;
  localparam int unsigned DEF_DW_LEN   = 9;
  localparam int unsigned DEF_GELU_LEN = 1;
  localparam int unsigned DEF_FC2_LEN  = 32;
  localparam int unsigned DEF_FC1_OUT  = 1;
  localparam int unsigned DEF_DW_OUT   = 1;
  localparam int unsigned DEF_GELU_OUT = 1;
  localparam int unsigned DEF_FC2_OUT  = 1;
  localparam int unsigned DEF_TIMEOUT  = 1023;

endpackage

// File: rtl/mixffn_seq_ctrl_if.sv
// Handshake/strobe bundle between the sequencer and the MixFFN datapath.
interface mixffn_seq_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             src_valid;
  logic             src_ready;
  logic             in_valid_fc1;
  logic             in_valid_dwconv;
  logic             in_valid_gelu;
  logic             in_valid_fc2;
  logic             out_valid_fc1;
  logic             out_valid_dwconv;
  logic             out_valid_gelu;
  logic             out_valid;
  logic [CNT_W-1:0] beat_idx;

  // Sequencer side: drives strobes and beat index, receives completions.
  modport master (
    input  src_valid,
    input  out_valid_fc1,
    input  out_valid_dwconv,
    input  out_valid_gelu,
    input  out_valid,
    output src_ready,
    output in_valid_fc1,
    output in_valid_dwconv,
    output in_valid_gelu,
    output in_valid_fc2,
    output beat_idx
  );

  // Datapath side.
  modport slave (
    output src_valid,
    output out_valid_fc1,
    output out_valid_dwconv,
    output out_valid_gelu,
    output out_valid,
    input  src_ready,
    input  in_valid_fc1,
    input  in_valid_dwconv,
    input  in_valid_gelu,
    input  in_valid_fc2,
    input  beat_idx
  );

endinterface

// File: rtl/mixffn_beat_cnt.sv
// Clear/enable up-counter with terminal-count compare.
module mixffn_beat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/mixffn_seq_ctrl.sv
// MixFFN run sequencer: feeds fc1 -> dwconv -> gelu -> fc2 in order, waits
// for each stage's completions, and flags timeouts and stray completions.
module mixffn_seq_ctrl
  import mixffn_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned FC1_LEN  = DEF_FC1_LEN,
  parameter int unsigned DW_LEN   = DEF_DW_LEN,
  parameter int unsigned GELU_LEN = DEF_GELU_LEN,
  parameter int unsigned FC2_LEN  = DEF_FC2_LEN,
  parameter int unsigned FC1_OUT  = DEF_FC1_OUT,
  parameter int unsigned DW_OUT   = DEF_DW_OUT,
  parameter int unsigned GELU_OUT = DEF_GELU_OUT,
  parameter int unsigned FC2_OUT  = DEF_FC2_OUT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              err_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        stage,
  mixffn_seq_ctrl_if.master bus
);

  ctrl_state_e state_q, state_d;
  stage_e      stage_q, stage_d;
  logic        err_q, err_d;

  logic [CNT_W-1:0] beat_cnt, out_cnt, wait_cnt;
  logic [CNT_W-1:0] len_sel, out_sel;
  logic             beat_tc, out_tc, wait_tc;
  logic             beat_clr, beat_en;
  logic             out_clr, out_en;
  logic             wait_clr, wait_en;

  logic             in_fc1, in_dw, in_gelu, in_fc2, beat_fire;
  logic [3:0]       ov_vec, act_mask;
  logic             act_ov, other_ov, err_set;

  // Per-stage feed length and expected completion count.
  always_comb begin
    len_sel = CNT_W'(FC1_LEN);
    out_sel = CNT_W'(FC1_OUT);
    case (stage_q)
      STG_FC1:  begin len_sel = CNT_W'(FC1_LEN);  out_sel = CNT_W'(FC1_OUT);  end
      STG_DW:   begin len_sel = CNT_W'(DW_LEN);   out_sel = CNT_W'(DW_OUT);   end
      STG_GELU: begin len_sel = CNT_W'(GELU_LEN); out_sel = CNT_W'(GELU_OUT); end
      STG_FC2:  begin len_sel = CNT_W'(FC2_LEN);  out_sel = CNT_W'(FC2_OUT);  end
      default:  begin len_sel = CNT_W'(FC1_LEN);  out_sel = CNT_W'(FC1_OUT);  end
    endcase
  end

  // Strobe decode from registered state, plus completion classification.
  always_comb begin
    in_fc1    = (state_q == ST_FEED) && (stage_q == STG_FC1) && bus.src_valid;
    in_dw     = (state_q == ST_FEED) && (stage_q == STG_DW);
    in_gelu   = (state_q == ST_FEED) && (stage_q == STG_GELU);
    in_fc2    = (state_q == ST_FEED) && (stage_q == STG_FC2);
    beat_fire = in_fc1 || in_dw || in_gelu || in_fc2;
    ov_vec    = {bus.out_valid, bus.out_valid_gelu, bus.out_valid_dwconv, bus.out_valid_fc1};
    act_mask  = 4'b0001 << stage_q;
    act_ov    = |(ov_vec & act_mask);
    other_ov  = |(ov_vec & ~act_mask);
  end

  // Run FSM: next state, stage and counter controls.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    beat_clr = 1'b0;
    beat_en  = 1'b0;
    out_clr  = 1'b0;
    out_en   = 1'b0;
    wait_clr = 1'b0;
    wait_en  = 1'b0;
    err_set  = 1'b0;

    // Completions count in FEED and WAIT; a pulse past the expected count
    // saturates out_cnt and is reported instead.
    if ((state_q == ST_FEED) || (state_q == ST_WAIT)) begin
      if (act_ov) begin
        if (out_tc) begin
          err_set = 1'b1;
        end else begin
          out_en = 1'b1;
        end
      end
    end
    if ((state_q != ST_IDLE) && (other_ov || (act_ov && (state_q == ST_DONE)))) begin
      err_set = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FEED;
          stage_d  = STG_FC1;
          beat_clr = 1'b1;
          out_clr  = 1'b1;
          wait_clr = 1'b1;
        end
      end
      ST_FEED: begin
        if (beat_fire) begin
          if (beat_tc) begin
            state_d  = ST_WAIT;
            wait_clr = 1'b1;
          end else begin
            beat_en = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Registered out_cnt is checked, so a completion that lands with the
        // last feed beat still costs exactly one WAIT cycle.
        if (out_tc) begin
          beat_clr = 1'b1;
          out_clr  = 1'b1;
          wait_clr = 1'b1;
          if (stage_q == STG_FC2) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FEED;
            stage_d = stage_e'(stage_q + 2'd1);
          end
        end else if (wait_tc) begin
          err_set  = 1'b1;
          state_d  = ST_IDLE;
          beat_clr = 1'b1;
          out_clr  = 1'b1;
          wait_clr = 1'b1;
        end else begin
          wait_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        beat_clr = 1'b1;
        out_clr  = 1'b1;
        wait_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: a new error event beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State, stage and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= STG_FC1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      err_q   <= err_d;
    end
  end

  mixffn_beat_cnt #(.W(CNT_W)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (beat_clr),
    .en   (beat_en),
    .term (len_sel - CNT_W'(1)),
    .cnt  (beat_cnt),
    .tc   (beat_tc)
  );

  mixffn_beat_cnt #(.W(CNT_W)) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (out_clr),
    .en   (out_en),
    .term (out_sel),
    .cnt  (out_cnt),
    .tc   (out_tc)
  );

  mixffn_beat_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (wait_clr),
    .en   (wait_en),
    .term (CNT_W'(TIMEOUT)),
    .cnt  (wait_cnt),
    .tc   (wait_tc)
  );

  assign bus.src_ready       = in_fc1;
  assign bus.in_valid_fc1    = in_fc1;
  assign bus.in_valid_dwconv = in_dw;
  assign bus.in_valid_gelu   = in_gelu;
  assign bus.in_valid_fc2    = in_fc2;
  assign bus.beat_idx        = beat_cnt;

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;
  assign stage = stage_q;

endmodule

// File: tb/tb_mixffn_seq_ctrl.sv
// Self-checking bench for mixffn_seq_ctrl: a responder model plays the
// datapath, a monitor measures each run and checks it against a scoreboard.
module tb_mixffn_seq_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst, start, err_clr;
  logic       busy, done, err;
  logic [1:0] stage;

  mixffn_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mixffn_seq_ctrl #(
    .CNT_W   (CNT_W),
    .FC1_LEN (16),
    .DW_LEN  (9),
    .GELU_LEN(1),
    .FC2_LEN (32),
    .FC1_OUT (1),
    .DW_OUT  (1),
    .GELU_OUT(1),
    .FC2_OUT (1),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .err_clr(err_clr),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .stage  (stage),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected shape of one run.
  typedef struct {
    int unsigned len0;
    int unsigned len1;
    int unsigned len2;
    int unsigned len3;
    int unsigned span;
    int unsigned dones;
    logic        err;
    bit          aborted;
  } run_t;

  run_t sb_q[$];

  function automatic logic strobe_of(input int unsigned s);
    case (s)
      0:       return bus.in_valid_fc1;
      1:       return bus.in_valid_dwconv;
      2:       return bus.in_valid_gelu;
      default: return bus.in_valid_fc2;
    endcase
  endfunction

  function automatic int unsigned len_of(input int unsigned s);
    case (s)
      0:       return 16;
      1:       return 9;
      2:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic run_t exp_run(input int unsigned span, input int unsigned dones,
                                   input logic e, input bit ab);
    run_t r;
    r.len0 = 16; r.len1 = 9; r.len2 = 1; r.len3 = 32;
    r.span = span; r.dones = dones; r.err = e; r.aborted = ab;
    return r;
  endfunction

  // Responder: one completion 3 cycles after the last feed beat of a stage,
  // or in the same cycle as that beat when sim_mode is set for the stage.
  bit          resp_en [4] = '{1, 1, 1, 1};
  bit          sim_mode[4] = '{0, 0, 0, 0};
  int unsigned stray_req_n = 0;
  int unsigned stray_ack_n = 0;
  int unsigned cd[4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    bit ov[4];
    #2;
    for (int s = 0; s < 4; s++) ov[s] = 1'b0;
    if (rst) begin
      for (int s = 0; s < 4; s++) cd[s] = 0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (cd[s] != 0) begin
          cd[s] = cd[s] - 1;
          if (cd[s] == 0) ov[s] = 1'b1;
        end
        if (resp_en[s] && strobe_of(s) && (bus.beat_idx == 16'(len_of(s) - 1))) begin
          if (sim_mode[s]) ov[s] = 1'b1;
          else             cd[s] = 3;
        end
      end
      if (stray_req_n != stray_ack_n) begin
        ov[2] = 1'b1;
        stray_ack_n = stray_req_n;
      end
    end
    bus.out_valid_fc1    = ov[0];
    bus.out_valid_dwconv = ov[1];
    bus.out_valid_gelu   = ov[2];
    bus.out_valid        = ov[3];
  end

  // Monitor: per-run strobe lengths, beat_idx sequence, done count, final err.
  int unsigned mon_len[4];
  int unsigned mon_cyc = 0, fc1_first = 0, fc1_last = 0, mon_dones = 0;
  bit          fc1_seen = 0, prev_busy = 0;

  always @(negedge clk) begin
    run_t e;
    mon_cyc++;
    if (busy && !prev_busy) begin
      for (int s = 0; s < 4; s++) mon_len[s] = 0;
      mon_dones = 0;
      fc1_seen  = 0;
    end
    if (busy) begin
      for (int s = 0; s < 4; s++) begin
        if (strobe_of(s)) begin
          chk($sformatf("beat_idx_s%0d", s), bus.beat_idx, mon_len[s]);
          chk($sformatf("stage_s%0d", s), stage, s);
          if (s == 0) begin
            chk("src_ready", bus.src_ready, 1);
            if (!fc1_seen) fc1_first = mon_cyc;
            fc1_seen = 1;
            fc1_last = mon_cyc;
          end
          mon_len[s]++;
        end
      end
      if (done) mon_dones++;
    end
    if (!busy && prev_busy) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_run", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("run_len_fc1", mon_len[0], e.len0);
        chk("run_done_cnt", mon_dones, e.dones);
        chk("run_err", err, e.err);
        if (!e.aborted) begin
          chk("run_len_dw", mon_len[1], e.len1);
          chk("run_len_gelu", mon_len[2], e.len2);
          chk("run_len_fc2", mon_len[3], e.len3);
          chk("run_fc1_span", fc1_seen ? fc1_last - fc1_first + 1 : 0, e.span);
        end
      end
    end
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_beat(input int unsigned s, input int unsigned idx, input string tag);
    int unsigned n = 0;
    while (!(strobe_of(s) && bus.beat_idx == 16'(idx)) && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, strobe_of(s) && bus.beat_idx == 16'(idx), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bit          seen;
    rst = 1'b1; start = 1'b0; err_clr = 1'b0; bus.src_valid = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_stage", stage, 0);
    chk("rst_beat_idx", bus.beat_idx, 0);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_strobes", {bus.in_valid_fc1, bus.in_valid_dwconv, bus.in_valid_gelu, bus.in_valid_fc2}, 0);
    rst = 1'b0;
    tick();

    // Nominal run with start->strobe latency check.
    sb_q.push_back(exp_run(16, 1, 1'b0, 0));
    do_start();
    chk("lat_fc1_strobe", bus.in_valid_fc1, 1);
    chk("lat_busy", busy, 1);
    wait_idle("nominal");

    // src_valid alternating during fc1.
    sb_q.push_back(exp_run(31, 1, 1'b0, 0));
    bus.src_valid = 1'b0;
    do_start();
    bus.src_valid = 1'b1;
    n = 0;
    while (stage == 2'd0 && busy && n < 100) begin
      tick();
      bus.src_valid = ~bus.src_valid;
      n++;
    end
    bus.src_valid = 1'b1;
    wait_idle("toggle");

    // Last fc1 beat coincides with the fc1 completion.
    sim_mode[0] = 1;
    sb_q.push_back(exp_run(16, 1, 1'b0, 0));
    do_start();
    wait_beat(0, 15, "sim_last_beat");
    tick();
    chk("sim_wait_fc1_low", bus.in_valid_fc1, 0);
    chk("sim_wait_dw_low", bus.in_valid_dwconv, 0);
    chk("sim_wait_stage", stage, 0);
    chk("sim_wait_busy", busy, 1);
    tick();
    chk("sim_dw_high", bus.in_valid_dwconv, 1);
    chk("sim_dw_stage", stage, 1);
    sim_mode[0] = 0;
    wait_idle("sim");

    // Stray gelu completion during DW; start while busy is ignored.
    sb_q.push_back(exp_run(16, 1, 1'b1, 0));
    do_start();
    wait_beat(1, 0, "stray_dw");
    stray_req_n++;
    tick();
    tick();
    chk("stray_err_now", err, 1);
    do_start();
    wait_idle("stray");
    chk("stray_err_end", err, 1);
    seen = 0;
    repeat (6) begin
      tick();
      if (busy) seen = 1;
    end
    chk("no_second_run", seen, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_stray", err, 0);

    // No fc2 completion: timeout.
    resp_en[3] = 0;
    sb_q.push_back(exp_run(16, 0, 1'b1, 0));
    do_start();
    wait_beat(3, 31, "to_last_fc2");
    n = 0;
    while (busy && n < 1100) begin
      tick();
      n++;
    end
    chk("timeout_len", (n >= TIMEOUT + 1) && (n <= TIMEOUT + 2), 1);
    chk("timeout_err", err, 1);
    chk("timeout_done", done, 0);
    resp_en[3] = 1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_timeout", err, 0);

    // Reset in the middle of the DW feed.
    sb_q.push_back(exp_run(16, 0, 1'b0, 1));
    do_start();
    wait_beat(1, 4, "abort_dw4");
    rst = 1'b1;
    #1;
    chk("abort_strobes", {bus.in_valid_fc1, bus.in_valid_dwconv, bus.in_valid_gelu, bus.in_valid_fc2}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Clean run after the abort.
    sb_q.push_back(exp_run(16, 1, 1'b0, 0));
    do_start();
    chk("post_abort_fc1", bus.in_valid_fc1, 1);
    chk("post_abort_stage", stage, 0);
    wait_idle("post_abort");
    tick();
    tick();
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
